// File: rtl/dma_tx_rq_arbiter.sv
// dma_tx_rq_arbiter: multi-channel front end for the single TX DMA request port.
// Arbitrates channel descriptor requests round-robin, caps outstanding requests
// per channel, and routes completions back using a {channel, channel_tag} tag.
//
// Handshake rule for every port pair here: a transfer happens in the cycle where
// valid && ready are both high; a source holds valid and its payload stable until
// that cycle, and ready may depend combinationally on valid.
module dma_tx_rq_arbiter #(
  parameter int RAM_ADDR_WIDTH = 18,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int DATA_BITS      = 3,
  parameter int CH_BITS        = 2,
  parameter int CTAG_BITS      = 4,
  parameter int MAX_OUTST      = 8
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic [(1<<CH_BITS)-1:0]                                     ch_enable,
  input  logic [(1<<CH_BITS)-1:0]                                     s_ch_valid,
  output logic [(1<<CH_BITS)-1:0]                                     s_ch_ready,
  input  logic [(1<<CH_BITS)*(RAM_ADDR_WIDTH-DATA_BITS+1)-1:0]        s_ch_loc_addr,
  input  logic [(1<<CH_BITS)*(BUS_ADDR_WIDTH-DATA_BITS)-1:0]          s_ch_bus_addr,
  input  logic [(1<<CH_BITS)*(RAM_ADDR_WIDTH-DATA_BITS)-1:0]          s_ch_length,
  input  logic [(1<<CH_BITS)*CTAG_BITS-1:0]                           s_ch_tag,
  output logic                                                        m_rq_valid,
  input  logic                                                        m_rq_ready,
  output logic [RAM_ADDR_WIDTH-DATA_BITS:0]                           m_rq_loc_addr,
  output logic [BUS_ADDR_WIDTH-DATA_BITS-1:0]                         m_rq_bus_addr,
  output logic [RAM_ADDR_WIDTH-DATA_BITS-1:0]                         m_rq_length,
  output logic [CH_BITS+CTAG_BITS-1:0]                                m_rq_tag,
  input  logic                                                        s_rc_valid,
  output logic                                                        s_rc_ready,
  input  logic [CH_BITS+CTAG_BITS-1:0]                                s_rc_tag,
  output logic [(1<<CH_BITS)-1:0]                                     m_cpl_valid,
  input  logic [(1<<CH_BITS)-1:0]                                     m_cpl_ready,
  output logic [CTAG_BITS-1:0]                                        m_cpl_tag,
  output logic [(1<<CH_BITS)*(CTAG_BITS+1)-1:0]                       ch_outst,
  output logic                                                        err_underflow,
  output logic [0:0]                                                  dbg_state
);

  localparam int CHANNELS = 1 << CH_BITS;
  localparam int LOC_W    = RAM_ADDR_WIDTH - DATA_BITS + 1;
  localparam int BUS_W    = BUS_ADDR_WIDTH - DATA_BITS;
  localparam int LEN_W    = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int UT_W     = CH_BITS + CTAG_BITS;
  localparam int OUT_W    = CTAG_BITS + 1;

  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_REQ = 1'b1;

  logic [0:0]           state;
  logic [CH_BITS-1:0]   rr_ptr;
  logic [CH_BITS-1:0]   grant_ch;
  logic [CH_BITS-1:0]   pick_ch;
  logic [CH_BITS-1:0]   scan_idx;
  logic                 pick_found;
  logic [CHANNELS-1:0]  elig;
  logic [OUT_W-1:0]     outst [CHANNELS];
  logic                 rq_fire;
  logic                 rc_fire;
  logic [CH_BITS-1:0]   rc_ch;
  logic [CHANNELS-1:0]  cpl_vld;
  logic [CTAG_BITS-1:0] cpl_tag;

  assign dbg_state  = state;
  assign m_rq_valid = (state == ST_REQ);
  assign rq_fire    = m_rq_valid && m_rq_ready;
  assign rc_ch      = s_rc_tag[UT_W-1:CTAG_BITS];
  assign s_rc_ready = !(|cpl_vld) || (|(cpl_vld & m_cpl_ready));
  assign rc_fire    = s_rc_valid && s_rc_ready;
  assign m_cpl_valid = cpl_vld;
  assign m_cpl_tag   = cpl_tag;

  // A channel may compete when it has a request, is enabled and is under its cap.
  always_comb begin
    elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      elig[i] = s_ch_valid[i] && ch_enable[i] && (outst[i] < OUT_W'(MAX_OUTST));
    end
  end

  // Round-robin scan starting just after the last granted channel.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    scan_idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      scan_idx = rr_ptr + CH_BITS'(k);
      if (!pick_found && elig[scan_idx]) begin
        pick_found = 1'b1;
        pick_ch    = scan_idx;
      end
    end
  end

  // Arbitration FSM: latch a grant in ARB, hold it in REQ until the DMA accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      rr_ptr   <= CH_BITS'(CHANNELS - 1);
      grant_ch <= '0;
    end else if (state == ST_ARB) begin
      if (pick_found) begin
        grant_ch <= pick_ch;
        state    <= ST_REQ;
      end
    end else if (rq_fire) begin
      rr_ptr <= grant_ch;
      state  <= ST_ARB;
    end
  end

  // Request fields come straight from the granted channel's input slice.
  always_comb begin
    m_rq_loc_addr = s_ch_loc_addr[int'(grant_ch)*LOC_W +: LOC_W];
    m_rq_bus_addr = s_ch_bus_addr[int'(grant_ch)*BUS_W +: BUS_W];
    m_rq_length   = s_ch_length[int'(grant_ch)*LEN_W +: LEN_W];
    m_rq_tag      = {grant_ch, s_ch_tag[int'(grant_ch)*CTAG_BITS +: CTAG_BITS]};
  end

  // One-hot accept pulse back to the granted channel in the handshake cycle.
  always_comb begin
    s_ch_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s_ch_ready[i] = rq_fire && (grant_ch == CH_BITS'(i));
    end
  end

  // Single-entry completion stage: load on accept, otherwise clear once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpl_vld <= '0;
      cpl_tag <= '0;
    end else if (rc_fire) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cpl_vld[i] <= (rc_ch == CH_BITS'(i));
      end
      cpl_tag <= s_rc_tag[CTAG_BITS-1:0];
    end else if (|(cpl_vld & m_cpl_ready)) begin
      cpl_vld <= '0;
    end
  end

  // Outstanding counters: issue increments, completion decrements (saturating at 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (rq_fire && (grant_ch == CH_BITS'(i)) &&
            !(rc_fire && (rc_ch == CH_BITS'(i)) && (outst[i] != '0))) begin
          outst[i] <= outst[i] + 1'b1;
        end else if (!(rq_fire && (grant_ch == CH_BITS'(i))) &&
                     rc_fire && (rc_ch == CH_BITS'(i)) && (outst[i] != '0)) begin
          outst[i] <= outst[i] - 1'b1;
        end
      end
    end
  end

  // Sticky flag for a completion that names a channel with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (rc_fire && (outst[rc_ch] == '0)) begin
      err_underflow <= 1'b1;
    end
  end

  // Flatten the counters onto the packed debug/status port.
  always_comb begin
    ch_outst = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_outst[i*OUT_W +: OUT_W] = outst[i];
    end
  end

endmodule

// File: tb/tb_dma_tx_rq_arbiter.sv
// tb_dma_tx_rq_arbiter: directed scenarios followed by a randomized run checked
// against a transaction-level reference model (round-robin scan, per-channel
// counts, and an in-order completion queue).
module tb_dma_tx_rq_arbiter;

  localparam int CH   = 4;
  localparam int CB   = 2;
  localparam int LW   = 16;
  localparam int BW   = 29;
  localparam int LENW = 15;
  localparam int CT   = 4;
  localparam int UT   = 6;
  localparam int OW   = 5;
  localparam int MAXO = 8;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     ch_enable;
  logic [CH-1:0]     s_ch_valid;
  logic [CH-1:0]     s_ch_ready;
  logic [CH*LW-1:0]  s_ch_loc_addr;
  logic [CH*BW-1:0]  s_ch_bus_addr;
  logic [CH*LENW-1:0] s_ch_length;
  logic [CH*CT-1:0]  s_ch_tag;
  logic              m_rq_valid;
  logic              m_rq_ready;
  logic [LW-1:0]     m_rq_loc_addr;
  logic [BW-1:0]     m_rq_bus_addr;
  logic [LENW-1:0]   m_rq_length;
  logic [UT-1:0]     m_rq_tag;
  logic              s_rc_valid;
  logic              s_rc_ready;
  logic [UT-1:0]     s_rc_tag;
  logic [CH-1:0]     m_cpl_valid;
  logic [CH-1:0]     m_cpl_ready;
  logic [CT-1:0]     m_cpl_tag;
  logic [CH*OW-1:0]  ch_outst;
  logic              err_underflow;
  logic [0:0]        dbg_state;

  dma_tx_rq_arbiter dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable),
    .s_ch_valid(s_ch_valid), .s_ch_ready(s_ch_ready),
    .s_ch_loc_addr(s_ch_loc_addr), .s_ch_bus_addr(s_ch_bus_addr),
    .s_ch_length(s_ch_length), .s_ch_tag(s_ch_tag),
    .m_rq_valid(m_rq_valid), .m_rq_ready(m_rq_ready),
    .m_rq_loc_addr(m_rq_loc_addr), .m_rq_bus_addr(m_rq_bus_addr),
    .m_rq_length(m_rq_length), .m_rq_tag(m_rq_tag),
    .s_rc_valid(s_rc_valid), .s_rc_ready(s_rc_ready), .s_rc_tag(s_rc_tag),
    .m_cpl_valid(m_cpl_valid), .m_cpl_ready(m_cpl_ready), .m_cpl_tag(m_cpl_tag),
    .ch_outst(ch_outst), .err_underflow(err_underflow), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state for the randomized phase
  logic [UT-1:0] exp_q[$];
  int            outst_m [CH];
  int            last_grant;
  int            cur_grant;
  logic          prev_valid;
  logic          prev_fire;
  logic [CH-1:0] elig_prev;
  logic [CH-1:0] acc;
  logic          rc_acc;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic v, input logic [LW-1:0] loc,
                        input logic [BW-1:0] bus, input logic [LENW-1:0] len,
                        input logic [CT-1:0] tg);
    s_ch_valid[c]              = v;
    s_ch_loc_addr[c*LW +: LW]  = loc;
    s_ch_bus_addr[c*BW +: BW]  = bus;
    s_ch_length[c*LENW +: LENW] = len;
    s_ch_tag[c*CT +: CT]       = tg;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ch_enable = '0; s_ch_valid = '0; s_ch_loc_addr = '0; s_ch_bus_addr = '0;
    s_ch_length = '0; s_ch_tag = '0; m_rq_ready = 1'b0;
    s_rc_valid = 1'b0; s_rc_tag = '0; m_cpl_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int scan(input int last, input logic [CH-1:0] e);
    for (int k = 1; k <= CH; k++) begin
      if (e[(last + k) % CH]) return (last + k) % CH;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] outst_of(input int c);
    return ch_outst[c*OW +: OW];
  endfunction

  initial begin
    int cnt;
    int c;
    logic          exp_valid;
    logic          fire;
    logic          rc_fire;
    logic          cons;
    logic          do_dec;
    logic          exp_rc_rdy;
    logic [CH-1:0] exp_rdy;
    logic [CH-1:0] exp_cv;
    logic [UT-1:0] front;
    logic [CH*OW-1:0] exp_o;

    rst = 1'b1;
    do_reset();
    @(negedge clk);
    #1;
    // Reset state
    chk("rst_rq_valid", m_rq_valid, 0);
    chk("rst_ch_ready", s_ch_ready, 0);
    chk("rst_cpl_valid", m_cpl_valid, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_outst", ch_outst, 0);
    chk("rst_rc_ready", s_rc_ready, 1);
    chk("rst_state", dbg_state, 0);

    // Single channel 1 request
    ch_enable = 4'hF;
    set_ch(1, 1'b1, 16'h0123, 29'h00ABCDE0, 15'h001F, 4'h3);
    m_rq_ready = 1'b0;
    #1 chk("t1_not_yet", m_rq_valid, 0);
    @(negedge clk); #1;
    chk("t1_valid", m_rq_valid, 1);
    chk("t1_tag", m_rq_tag, 6'h13);
    chk("t1_len", m_rq_length, 15'h1F);
    chk("t1_loc", m_rq_loc_addr, 16'h0123);
    chk("t1_bus", m_rq_bus_addr, 29'h00ABCDE0);
    chk("t1_no_ready", s_ch_ready, 0);
    m_rq_ready = 1'b1;
    #1 chk("t1_ready_pulse", s_ch_ready, 4'b0010);
    @(negedge clk);
    s_ch_valid = '0; m_rq_ready = 1'b0;
    #1;
    chk("t1_outst1", outst_of(1), 1);
    chk("t1_idle", m_rq_valid, 0);

    // All channels continuously valid: round-robin, two cycles per grant
    do_reset();
    ch_enable = 4'hF; m_rq_ready = 1'b1;
    for (int i = 0; i < CH; i++) set_ch(i, 1'b1, LW'(i), BW'(i), LENW'(i), CT'(i));
    #1 chk("t2_first_idle", m_rq_valid, 0);
    for (int g = 0; g < 8; g++) begin
      @(negedge clk); #1;
      chk("t2_valid", m_rq_valid, 1);
      chk("t2_grant_ch", m_rq_tag[UT-1:CT], g % CH);
      chk("t2_loc", m_rq_loc_addr, g % CH);
      chk("t2_ready", s_ch_ready, 4'b0001 << (g % CH));
      @(negedge clk); #1;
      chk("t2_gap", m_rq_valid, 0);
    end
    for (int i = 0; i < CH; i++) chk("t2_outst", outst_of(i), 2);

    // Outstanding cap on channel 2, then release by one completion
    do_reset();
    ch_enable = 4'hF; m_rq_ready = 1'b1;
    set_ch(2, 1'b1, 16'h0200, 29'h2000, 15'h7, 4'h9);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (s_ch_ready[2]) cnt++;
    end
    chk("t3_grant_count", cnt, 8);
    chk("t3_outst_cap", outst_of(2), 8);
    chk("t3_blocked", m_rq_valid, 0);
    s_rc_valid = 1'b1; s_rc_tag = 6'h25; m_cpl_ready = '0;
    #1 chk("t3_rc_ready", s_rc_ready, 1);
    @(negedge clk);
    s_rc_valid = 1'b0;
    #1;
    chk("t3_cpl_valid", m_cpl_valid, 4'b0100);
    chk("t3_cpl_tag", m_cpl_tag, 5);
    chk("t3_outst_dec", outst_of(2), 7);
    chk("t3_arb_cycle", m_rq_valid, 0);
    @(negedge clk); #1;
    chk("t3_regrant", m_rq_valid, 1);
    chk("t3_regrant_ch", m_rq_tag[UT-1:CT], 2);

    // Completion back-pressure: second completion stalls, then delivered in order
    @(negedge clk);
    s_ch_valid = '0;
    s_rc_valid = 1'b1; s_rc_tag = 6'h2A;
    #1 chk("t4_stall0", s_rc_ready, 0);
    @(negedge clk); #1;
    chk("t4_stall1", s_rc_ready, 0);
    chk("t4_hold_tag", m_cpl_tag, 5);
    chk("t4_hold_valid", m_cpl_valid, 4'b0100);
    m_cpl_ready = 4'b0100;
    #1 chk("t4_release", s_rc_ready, 1);
    @(negedge clk);
    s_rc_valid = 1'b0;
    #1;
    chk("t4_second_valid", m_cpl_valid, 4'b0100);
    chk("t4_second_tag", m_cpl_tag, 4'hA);
    chk("t4_outst", outst_of(2), 7);
    @(negedge clk); #1;
    chk("t4_drained", m_cpl_valid, 0);

    // Same-cycle issue and completion on channel 0, then underflow on idle channel 3
    do_reset();
    ch_enable = 4'hF; m_rq_ready = 1'b1; m_cpl_ready = 4'hF;
    set_ch(0, 1'b1, 16'h0010, 29'h10, 15'h3, 4'h1);
    for (int n = 0; n < 6; n++) @(negedge clk);
    #1;
    chk("t5_outst3", outst_of(0), 3);
    chk("t5_arb", m_rq_valid, 0);
    @(negedge clk);
    s_rc_valid = 1'b1; s_rc_tag = 6'h01;
    #1;
    chk("t5_issue", s_ch_ready, 4'b0001);
    chk("t5_rc_ready", s_rc_ready, 1);
    @(negedge clk);
    s_ch_valid = '0;
    s_rc_tag = 6'h37;
    #1;
    chk("t5_outst_same", outst_of(0), 3);
    chk("t5_cpl0", m_cpl_valid, 4'b0001);
    chk("t5_no_err_yet", err_underflow, 0);
    @(negedge clk);
    s_rc_valid = 1'b0;
    #1;
    chk("t5_err", err_underflow, 1);
    chk("t5_outst3_zero", outst_of(3), 0);
    chk("t5_fwd", m_cpl_valid, 4'b1000);
    chk("t5_fwd_tag", m_cpl_tag, 7);

    // Disabling a channel after its grant does not withdraw the request
    do_reset();
    ch_enable = 4'hF; m_rq_ready = 1'b0;
    set_ch(1, 1'b1, 16'h0111, 29'h111, 15'h1, 4'h1);
    @(negedge clk); #1;
    chk("t6_valid", m_rq_valid, 1);
    ch_enable[1] = 1'b0;
    @(negedge clk); #1;
    chk("t6_sticky", m_rq_valid, 1);
    chk("t6_sticky_ch", m_rq_tag[UT-1:CT], 1);
    m_rq_ready = 1'b1;
    #1 chk("t6_accept", s_ch_ready, 4'b0010);
    @(negedge clk);
    set_ch(2, 1'b1, 16'h0222, 29'h222, 15'h2, 4'h2);
    #1 chk("t6_gap", m_rq_valid, 0);
    @(negedge clk); #1;
    chk("t6_skip_to2", m_rq_tag[UT-1:CT], 2);
    chk("t6_valid2", m_rq_valid, 1);
    @(negedge clk);
    s_ch_valid[2] = 1'b0;
    #1 chk("t6_gap2", m_rq_valid, 0);
    @(negedge clk); #1;
    chk("t6_disabled_skip", m_rq_valid, 0);
    ch_enable[1] = 1'b1;
    @(negedge clk); #1;
    chk("t6_reenabled", m_rq_valid, 1);
    chk("t6_reenabled_ch", m_rq_tag[UT-1:CT], 1);

    // Randomized traffic against the reference model
    do_reset();
    exp_q.delete();
    for (int i = 0; i < CH; i++) outst_m[i] = 0;
    last_grant = CH - 1; cur_grant = 0;
    prev_valid = 1'b0; prev_fire = 1'b0; elig_prev = '0; acc = '0; rc_acc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        if (!s_ch_valid[i] || acc[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_ch(i, 1'b1, LW'($urandom), BW'($urandom), LENW'($urandom), CT'($urandom));
          else
            s_ch_valid[i] = 1'b0;
        end
        ch_enable[i] = ($urandom_range(0, 4) != 0);
      end
      m_rq_ready  = ($urandom_range(0, 1) == 1);
      m_cpl_ready = CH'($urandom);
      if (!s_rc_valid || rc_acc) begin
        c = $urandom_range(0, CH - 1);
        s_rc_valid = (outst_m[c] > 0) && ($urandom_range(0, 1) == 1);
        s_rc_tag   = {CB'(c), CT'($urandom)};
      end
      #1;
      // Request side: one cycle to grant, held until accepted, idle cycle after
      if (prev_fire) exp_valid = 1'b0;
      else if (prev_valid) exp_valid = 1'b1;
      else if (elig_prev != '0) begin
        exp_valid = 1'b1;
        cur_grant = scan(last_grant, elig_prev);
      end else exp_valid = 1'b0;
      chk("r_rq_valid", m_rq_valid, exp_valid);
      if (exp_valid) begin
        chk("r_rq_tag", m_rq_tag, {CB'(cur_grant), s_ch_tag[cur_grant*CT +: CT]});
        chk("r_rq_loc", m_rq_loc_addr, s_ch_loc_addr[cur_grant*LW +: LW]);
        chk("r_rq_bus", m_rq_bus_addr, s_ch_bus_addr[cur_grant*BW +: BW]);
        chk("r_rq_len", m_rq_length, s_ch_length[cur_grant*LENW +: LENW]);
      end
      fire = exp_valid && m_rq_ready;
      exp_rdy = '0;
      if (fire) exp_rdy[cur_grant] = 1'b1;
      chk("r_ch_ready", s_ch_ready, exp_rdy);
      // Completion side: at most one entry held, delivered in arrival order
      exp_cv = '0;
      front = '0;
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        exp_cv[front[UT-1:CT]] = 1'b1;
      end
      exp_rc_rdy = (exp_q.size() == 0) || m_cpl_ready[front[UT-1:CT]];
      chk("r_rc_ready", s_rc_ready, exp_rc_rdy);
      chk("r_cpl_valid", m_cpl_valid, exp_cv);
      if (exp_q.size() > 0) chk("r_cpl_tag", m_cpl_tag, front[CT-1:0]);
      exp_o = '0;
      for (int i = 0; i < CH; i++) exp_o[i*OW +: OW] = OW'(outst_m[i]);
      chk("r_outst", ch_outst, exp_o);
      // Advance the model across the coming clock edge
      rc_fire = s_rc_valid && exp_rc_rdy;
      cons    = (exp_q.size() > 0) && m_cpl_ready[front[UT-1:CT]];
      for (int i = 0; i < CH; i++)
        elig_prev[i] = s_ch_valid[i] && ch_enable[i] && (outst_m[i] < MAXO);
      if (cons) void'(exp_q.pop_front());
      if (rc_fire) exp_q.push_back(s_rc_tag);
      c = int'(s_rc_tag[UT-1:CT]);
      do_dec = rc_fire && (outst_m[c] > 0);
      if (fire) outst_m[cur_grant]++;
      if (do_dec) outst_m[c]--;
      prev_valid = exp_valid;
      prev_fire  = fire;
      if (fire) last_grant = cur_grant;
      acc    = exp_rdy;
      rc_acc = rc_fire;
    end
    #1 chk("r_no_underflow", err_underflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_tx_rq_arbiter.md
Name: dma_tx_rq_arbiter

Overview:
- Multi-channel front end for the single TX DMA request port (loc_addr/bus_addr/length/tag request in, user-tag completion out).
- Arbitrates descriptor requests from CHANNELS independent TX streams round-robin.
- Enforces a per-channel outstanding-request limit.
- Routes completions back to the owning channel using a {channel, channel_tag} user tag.

Parameters:
- RAM_ADDR_WIDTH, 18, local buffer address width.
- BUS_ADDR_WIDTH, 32, host bus address width.
- DATA_BITS, 3, log2 of bus word bytes; addresses and lengths are in words.
- CH_BITS, 2, log2 of channel count; CHANNELS = 1<<CH_BITS.
- CTAG_BITS, 4, per-channel tag width; USER_TAG_BITS = CH_BITS+CTAG_BITS.
- MAX_OUTST, 8, maximum accepted-but-uncompleted requests per channel (1..2^CTAG_BITS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ch_enable  in  CHANNELS  per-channel arbitration enable.
- s_ch_valid  in  CHANNELS  channel request valid.
- s_ch_ready  out  CHANNELS  channel request accepted (one-hot pulse).
- s_ch_loc_addr  in  CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS+1)  packed, channel 0 in LSBs.
- s_ch_bus_addr  in  CHANNELS*(BUS_ADDR_WIDTH-DATA_BITS)  packed.
- s_ch_length  in  CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS)  packed; value is words-1.
- s_ch_tag  in  CHANNELS*CTAG_BITS  packed.
- m_rq_valid  out  1  to DMA request valid.
- m_rq_ready  in  1  DMA request accept.
- m_rq_loc_addr  out  RAM_ADDR_WIDTH-DATA_BITS+1  request field.
- m_rq_bus_addr  out  BUS_ADDR_WIDTH-DATA_BITS  request field.
- m_rq_length  out  RAM_ADDR_WIDTH-DATA_BITS  request field.
- m_rq_tag  out  USER_TAG_BITS  {grant_ch, channel tag}.
- s_rc_valid  in  1  DMA completion valid.
- s_rc_ready  out  1  completion accept.
- s_rc_tag  in  USER_TAG_BITS  completed user tag.
- m_cpl_valid  out  CHANNELS  one-hot completion to channel.
- m_cpl_ready  in  CHANNELS  per-channel completion accept.
- m_cpl_tag  out  CTAG_BITS  completed channel tag (shared).
- ch_outst  out  CHANNELS*(CTAG_BITS+1)  packed outstanding counters.
- err_underflow  out  1  sticky: completion arrived for a channel with zero outstanding.

Behaviour:
- Reset values: state ARB, rr_ptr=CHANNELS-1, all counters 0, m_rq_valid=0, s_ch_ready=0, m_cpl_valid=0, err_underflow=0.
- Eligibility: channel i is eligible iff s_ch_valid[i] && ch_enable[i] && outst[i] < MAX_OUTST.
- ARB state: select the first eligible channel scanning rr_ptr+1, rr_ptr+2, ... modulo CHANNELS; latch it as grant_ch; go to REQ. No eligible channel: stay in ARB.
- REQ state:
  - m_rq_valid=1.
  - m_rq_* is driven from the grant_ch input slices; channels hold their fields stable while valid.
  - On m_rq_valid && m_rq_ready: s_ch_ready[grant_ch]=1 combinationally that cycle, outst[grant_ch]++, rr_ptr<=grant_ch, next state ARB.
- Request latency: earliest m_rq_valid is one cycle after eligibility. Minimum spacing between grants is 2 cycles.
- Grant stickiness: once in REQ, the grant is never withdrawn, even if ch_enable or the limit changes. The request is held until accepted.
- Completion output stage is a single register.
  - s_rc_ready = !any(m_cpl_valid) || m_cpl_ready[held channel].
  - On s_rc_valid && s_rc_ready: m_cpl_valid <= onehot(s_rc_tag[USER_TAG_BITS-1:CTAG_BITS]), m_cpl_tag <= low bits.
  - Also decrement that channel's counter on acceptance.
  - Otherwise a consumed entry clears m_cpl_valid.
- Simultaneous issue and completion on the same channel in one cycle: the counter is unchanged.
- Underflow: a completion for a channel with outst=0 keeps the counter at 0, sets err_underflow, and is still forwarded.
- A channel at MAX_OUTST becomes eligible again on the cycle after its decrement.
- Reset mid-operation drops any pending grant and completion without handshake. The downstream DMA is reset by the same rst.

Test Plan:
- Single channel 1, length=0x1F, tag=3 → m_rq_valid on cycle 2 with m_rq_tag=0x13; s_ch_ready[1] pulses in the m_rq_ready cycle; ch_outst[1]=1.
- All 4 channels valid continuously, m_rq_ready always 1 → grant order 0,1,2,3,0…; each grant 2 cycles apart.
- Channel 2 with MAX_OUTST=8 and no completions → exactly 8 grants, then no more; one completion tag 0x25 → m_cpl_valid[2], m_cpl_tag=5, next grant follows.
- m_cpl_ready held 0 with a completion pending → s_rc_ready=0; second completion stalls until release; no loss and in-order delivery.
- Same-cycle accept and completion on channel 0 with outst=3 → outst stays 3; completion for an idle channel → err_underflow=1 and counter stays 0.
- Deassert ch_enable[1] during REQ for channel 1 → request still completes; channel 1 is then skipped until re-enabled.
